// File: rtl/regfile_hilo_if.sv
// regfile_hilo_if: writeback-side write bus and decode-side read bus of the register file
interface regfile_hilo_if;
  logic        write_enable;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [1:0]  write_hilo;
  logic [31:0] hi_data;
  logic [31:0] lo_data;
  logic        read_enable1;
  logic        read_enable2;
  logic [4:0]  read_addr1;
  logic [4:0]  read_addr2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] gpr_commits;
  logic [31:0] hilo_commits;
  modport master (
    output write_enable, write_addr, write_data, write_hilo, hi_data, lo_data,
    output read_enable1, read_enable2, read_addr1, read_addr2,
    input  read_data1, read_data2, hi, lo, gpr_commits, hilo_commits
  );
  modport slave (
    input  write_enable, write_addr, write_data, write_hilo, hi_data, lo_data,
    input  read_enable1, read_enable2, read_addr1, read_addr2,
    output read_data1, read_data2, hi, lo, gpr_commits, hilo_commits
  );
endinterface

// File: rtl/regfile_hilo.sv
// regfile_hilo: 32x32 GPR file plus HI/LO with write-through bypass and saturating commit counters
module regfile_hilo (
  input logic          clk,
  input logic          rst,
  regfile_hilo_if.slave bus
);
  logic [31:0] regs [32];
  logic [31:0] hi_q, lo_q, gpr_cnt, hilo_cnt;
  logic        gpr_wr, hilo_wr;
  assign gpr_wr  = bus.write_enable && (bus.write_addr != 5'd0);
  assign hilo_wr = |bus.write_hilo;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      gpr_cnt  <= '0;
      hilo_cnt <= '0;
    end else begin
      if (gpr_wr) regs[bus.write_addr] <= bus.write_data;
      if (bus.write_hilo[1]) hi_q <= bus.hi_data;
      if (bus.write_hilo[0]) lo_q <= bus.lo_data;
      gpr_cnt  <= gpr_cnt + {31'd0, gpr_wr && !(&gpr_cnt)};
      hilo_cnt <= hilo_cnt + {31'd0, hilo_wr && !(&hilo_cnt)};
    end
  // $0 is gated at the read mux, so a stale regs[0] can never leak out
  always_comb begin
    bus.read_data1 = (!bus.read_enable1 || bus.read_addr1 == 5'd0) ? 32'd0 :
                     (bus.write_enable && bus.write_addr == bus.read_addr1) ? bus.write_data :
                     regs[bus.read_addr1];
    bus.read_data2 = (!bus.read_enable2 || bus.read_addr2 == 5'd0) ? 32'd0 :
                     (bus.write_enable && bus.write_addr == bus.read_addr2) ? bus.write_data :
                     regs[bus.read_addr2];
    bus.hi = bus.write_hilo[1] ? bus.hi_data : hi_q;
    bus.lo = bus.write_hilo[0] ? bus.lo_data : lo_q;
  end
  assign bus.gpr_commits  = gpr_cnt;
  assign bus.hilo_commits = hilo_cnt;
endmodule
